// File: rtl/spi_line.sv
// spi_line: draws one line segment on an ILI9341 panel, one SPI bit per clock.
// The segment is walked with integer Bresenham. Each pixel is sent as one
// 13-byte frame: CASET, PASET, then RAMWR followed by the colour.
// Chip select stays low for the whole segment, so frames follow each other
// with no idle bit between them.
module spi_line #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        i_clk,
  input  logic        w_rst,
  input  logic        i_start,
  input  logic [8:0]  i_x0,
  input  logic [8:0]  i_x1,
  input  logic [8:0]  i_y0,
  input  logic [8:0]  i_y1,
  input  logic [15:0] i_color,
  output logic        o_mosi,
  output logic        o_dc,
  output logic        o_cs,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FIN} state_t;

  localparam logic [8:0] X_LIMIT   = 9'(WIDTH);
  localparam logic [8:0] Y_LIMIT   = 9'(HEIGHT);
  localparam logic [3:0] LAST_BYTE = 4'd12;

  // Byte idx of the per-pixel frame. Coordinates are zero-extended to 16 bits,
  // so each high byte carries only bit 8 of the coordinate.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [8:0]  x,
                                            input logic [8:0]  y,
                                            input logic [15:0] col);
    logic [7:0] b;
    case (idx)
      4'd0:       b = 8'h2A;
      4'd1, 4'd3: b = {7'd0, x[8]};
      4'd2, 4'd4: b = x[7:0];
      4'd5:       b = 8'h2B;
      4'd6, 4'd8: b = {7'd0, y[8]};
      4'd7, 4'd9: b = y[7:0];
      4'd10:      b = 8'h2C;
      4'd11:      b = col[15:8];
      4'd12:      b = col[7:0];
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

  // Registered state
  state_t             r_state;
  logic [3:0]         r_byte;
  logic [2:0]         r_bit;
  logic [8:0]         r_cur_x, r_cur_y;
  logic [8:0]         r_x1, r_y1;
  logic [15:0]        r_color;
  logic               r_sx_neg, r_sy_neg;
  logic signed [9:0]  r_dx, r_dy;
  logic signed [10:0] r_err;
  logic               r_mosi, r_dc, r_cs, r_busy, r_done;

  // Next-state values
  state_t             w_state_nxt;
  logic [3:0]         w_byte_nxt;
  logic [2:0]         w_bit_nxt;
  logic [8:0]         w_cur_x_nxt, w_cur_y_nxt;
  logic [8:0]         w_x1_nxt, w_y1_nxt;
  logic [15:0]        w_color_nxt;
  logic               w_sx_neg_nxt, w_sy_neg_nxt;
  logic signed [9:0]  w_dx_nxt, w_dy_nxt;
  logic signed [10:0] w_err_nxt;
  logic               w_mosi_nxt, w_dc_nxt, w_cs_nxt, w_busy_nxt, w_done_nxt;
  logic [7:0]         w_frame_byte;

  // Segment set-up terms, computed from the request inputs
  logic               w_x_neg, w_y_neg, w_in_range;
  logic [8:0]         w_adx, w_ady;
  logic signed [9:0]  w_dx0, w_dy0;
  logic signed [10:0] w_err0;

  assign w_x_neg    = (i_x1 < i_x0);
  assign w_y_neg    = (i_y1 < i_y0);
  assign w_adx      = w_x_neg ? (i_x0 - i_x1) : (i_x1 - i_x0);
  assign w_ady      = w_y_neg ? (i_y0 - i_y1) : (i_y1 - i_y0);
  assign w_dx0      = $signed({1'b0, w_adx});
  assign w_dy0      = -$signed({1'b0, w_ady});
  assign w_err0     = {w_dx0[9], w_dx0} + {w_dy0[9], w_dy0};
  assign w_in_range = (i_x0 < X_LIMIT) && (i_x1 < X_LIMIT) &&
                      (i_y0 < Y_LIMIT) && (i_y1 < Y_LIMIT);

  // Bresenham step terms: e2 = 2*err compared against the sign-extended deltas
  logic signed [11:0] w_e2, w_dx_ext, w_dy_ext;
  logic signed [10:0] w_dx_err, w_dy_err;
  logic               w_step_x, w_step_y, w_at_end;

  assign w_e2     = {r_err, 1'b0};
  assign w_dx_ext = {{2{r_dx[9]}}, r_dx};
  assign w_dy_ext = {{2{r_dy[9]}}, r_dy};
  assign w_dx_err = {r_dx[9], r_dx};
  assign w_dy_err = {r_dy[9], r_dy};
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);
  assign w_at_end = (r_cur_x == r_x1) && (r_cur_y == r_y1);

  // Next-state, bit sequencing, Bresenham walk, and the next registered outputs
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    w_state_nxt  = r_state;
    w_byte_nxt   = r_byte;
    w_bit_nxt    = r_bit;
    w_cur_x_nxt  = r_cur_x;
    w_cur_y_nxt  = r_cur_y;
    w_x1_nxt     = r_x1;
    w_y1_nxt     = r_y1;
    w_color_nxt  = r_color;
    w_sx_neg_nxt = r_sx_neg;
    w_sy_neg_nxt = r_sy_neg;
    w_dx_nxt     = r_dx;
    w_dy_nxt     = r_dy;
    w_err_nxt    = r_err;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_cs_nxt     = 1'b1;
    w_mosi_nxt   = 1'b0;
    w_dc_nxt     = 1'b0;
    w_frame_byte = 8'h00;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_x1_nxt    = i_x1;
          w_y1_nxt    = i_y1;
          w_color_nxt = i_color;
          if (!w_in_range) begin
            // Rejected request: report completion without touching the bus.
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_sx_neg_nxt = w_x_neg;
            w_sy_neg_nxt = w_y_neg;
            w_dx_nxt     = w_dx0;
            w_dy_nxt     = w_dy0;
            w_err_nxt    = w_err0;
            w_cur_x_nxt  = i_x0;
            w_cur_y_nxt  = i_y0;
            w_byte_nxt   = 4'd0;
            w_bit_nxt    = 3'd7;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_SEND;
          end
        end
      end

      S_SEND: begin
        if (r_bit != 3'd0) begin
          w_bit_nxt = r_bit - 3'd1;
        end else if (r_byte != LAST_BYTE) begin
          w_byte_nxt = r_byte + 4'd1;
          w_bit_nxt  = 3'd7;
        end else if (w_at_end) begin
          w_state_nxt = S_FIN;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          // Both axis updates use the same e2 and may apply together.
          if (w_step_x) begin
            w_err_nxt   = w_err_nxt + w_dy_err;
            w_cur_x_nxt = r_sx_neg ? (r_cur_x - 9'd1) : (r_cur_x + 9'd1);
          end
          if (w_step_y) begin
            w_err_nxt   = w_err_nxt + w_dx_err;
            w_cur_y_nxt = r_sy_neg ? (r_cur_y - 9'd1) : (r_cur_y + 9'd1);
          end
          w_byte_nxt = 4'd0;
          w_bit_nxt  = 3'd7;
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // The bus bit for the next cycle comes from the frame position being entered.
    if (w_state_nxt == S_SEND) begin
      w_cs_nxt     = 1'b0;
      w_frame_byte = frame_byte(w_byte_nxt, w_cur_x_nxt, w_cur_y_nxt, w_color_nxt);
      w_mosi_nxt   = w_frame_byte[w_bit_nxt];
      w_dc_nxt     = !((w_byte_nxt == 4'd0) || (w_byte_nxt == 4'd5) ||
                       (w_byte_nxt == 4'd10));
    end
  end

  // State and registered outputs; reset drops the transfer at once and releases cs
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state  <= S_IDLE;
      r_byte   <= 4'd0;
      r_bit    <= 3'd7;
      r_cur_x  <= 9'd0;
      r_cur_y  <= 9'd0;
      r_x1     <= 9'd0;
      r_y1     <= 9'd0;
      r_color  <= 16'd0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_dx     <= 10'sd0;
      r_dy     <= 10'sd0;
      r_err    <= 11'sd0;
      r_mosi   <= 1'b0;
      r_dc     <= 1'b0;
      r_cs     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees the pre-edge values.
      r_state  <= w_state_nxt;
      r_byte   <= w_byte_nxt;
      r_bit    <= w_bit_nxt;
      r_cur_x  <= w_cur_x_nxt;
      r_cur_y  <= w_cur_y_nxt;
      r_x1     <= w_x1_nxt;
      r_y1     <= w_y1_nxt;
      r_color  <= w_color_nxt;
      r_sx_neg <= w_sx_neg_nxt;
      r_sy_neg <= w_sy_neg_nxt;
      r_dx     <= w_dx_nxt;
      r_dy     <= w_dy_nxt;
      r_err    <= w_err_nxt;
      r_mosi   <= w_mosi_nxt;
      r_dc     <= w_dc_nxt;
      r_cs     <= w_cs_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign o_mosi = r_mosi;
  assign o_dc   = r_dc;
  assign o_cs   = r_cs;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
